// File: rtl/pmu_pkg.sv
// pmu_pkg: shared definitions for the AES sequencing controller.
//   state_t        : controller FSM states
//   HDR_CNT_*      : position of the block-count field inside the serial header
//   HDR_RSVD_MASK  : bits of the header (up to HDR_MAX_WIDTH) that are reserved,
//                    i.e. everything above the block-count field
package pmu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam int HDR_CNT_LSB   = 0;
    localparam int HDR_CNT_MSB   = 11;
    localparam int HDR_CNT_W     = HDR_CNT_MSB - HDR_CNT_LSB + 1;
    localparam int HDR_MAX_WIDTH = 64;

    localparam logic [HDR_MAX_WIDTH-1:0] HDR_RSVD_MASK =
        ~{{(HDR_MAX_WIDTH-HDR_CNT_W){1'b0}}, {HDR_CNT_W{1'b1}}};

endpackage

// File: rtl/aes_seq_shreg.sv
// aes_seq_shreg: serial-in deserializer, LSB-first.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clr          : synchronous clear of the word and bit count
//   shift_en     : shift bit_in in this cycle
//   bit_in       : serial input bit
//   word_next    : the word including the bit currently on bit_in; this is the
//                  completed word in the cycle where last=1 and shift_en=1
//   last         : the next shifted bit completes a WIDTH-bit word
module aes_seq_shreg #(
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             shift_en,
    input  logic             bit_in,
    output logic [WIDTH-1:0] word_next,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] word;
    logic [CW-1:0]    count;

    // New bits enter at the MSB so that after WIDTH shifts the first bit
    // received sits at bit 0.
    assign word_next = {bit_in, word[WIDTH-1:1]};
    assign last      = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word  <= '0;
            count <= '0;
        end else if (shift_en) begin
            word  <= word_next;
            count <= last ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: receives a serial header announcing a block count, then
// deserializes that many AES blocks, launches each on the AES core, waits a
// fixed latency and captures the result. pwr_up_en rises once every announced
// block has been captured.
// Ports:
//   clk, rst     : clock, synchronous active-high reset (priority over all)
//   en, data_i   : serial stream valid / data, LSB-first
//   aes_start    : one-cycle launch pulse; aes_block held until capture
//   aes_result   : AES core output, sampled AES_LATENCY cycles after launch
//   out_valid    : one-cycle strobe, out_data holds the captured result
//   pwr_up_en    : all announced blocks processed (DONE state)
//   err          : sticky header / sequencing error (ERROR state)
//   state_dbg    : current FSM state
// Optional feature: define AES_SEQ_HDR_CHECK_EN to require the reserved header
// bits above the block-count field to be zero.
//
// Handshake: there is no back-pressure. A serial bit is transferred on every
// rising edge where en=1; en falling mid-stream aborts the stream. aes_start
// is a single-cycle strobe, and out_valid is a single-cycle strobe that the
// consumer must accept in that cycle.
module aes_seq_ctrl
    import pmu_pkg::*;
#(
    parameter int HEADER_WIDTH   = 32,
    parameter int AES_DATA_WIDTH = 128,
    parameter int AES_LATENCY    = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      data_i,
    output logic                      aes_start,
    output logic [AES_DATA_WIDTH-1:0] aes_block,
    input  logic [AES_DATA_WIDTH-1:0] aes_result,
    output logic                      out_valid,
    output logic [AES_DATA_WIDTH-1:0] out_data,
    output logic                      pwr_up_en,
    output logic                      err,
    output state_t                    state_dbg
);

    // A block takes AES_DATA_WIDTH cycles to arrive, so a latency shorter than
    // that guarantees at most one block is ever in flight.
    if (AES_LATENCY >= AES_DATA_WIDTH || AES_LATENCY < 1) begin : g_bad_latency
        $fatal(1, "aes_seq_ctrl: AES_LATENCY must be in 1..AES_DATA_WIDTH-1");
    end
    if (HEADER_WIDTH <= HDR_CNT_W || HEADER_WIDTH > HDR_MAX_WIDTH) begin : g_bad_header
        $fatal(1, "aes_seq_ctrl: HEADER_WIDTH must be in 13..64");
    end

    localparam int LCW = $clog2(AES_LATENCY + 1);

    state_t state, state_nxt;

    logic [HEADER_WIDTH-1:0]   hdr_word;
    logic                      hdr_last;
    logic [AES_DATA_WIDTH-1:0] pay_word;
    logic                      pay_last;
    logic [HDR_CNT_W-1:0]      hdr_blk;
    logic [HDR_CNT_W-1:0]      blk_total;
    logic [HDR_CNT_W-1:0]      blk_cnt;
    logic [HDR_CNT_W-1:0]      blk_cnt_inc;
    logic [LCW-1:0]            lat_cnt;

    logic in_stream, abort;
    logic hdr_shift, hdr_fire, hdr_rsvd_err, hdr_err;
    logic pay_shift, launch_req, launch, overrun, capture;

    assign in_stream = (state == ST_HEADER) || (state == ST_PAYLOAD) || (state == ST_DRAIN);
    assign abort     = in_stream && !en;

    // The first header bit is taken in IDLE, in the same cycle en rises.
    assign hdr_shift = en && ((state == ST_IDLE) || (state == ST_HEADER));
    assign hdr_fire  = en && (state == ST_HEADER) && hdr_last;
    assign hdr_blk   = hdr_word[HDR_CNT_MSB:HDR_CNT_LSB];

`ifdef AES_SEQ_HDR_CHECK_EN
    assign hdr_rsvd_err = |(hdr_word & HDR_RSVD_MASK[HEADER_WIDTH-1:0]);
`else
    logic hdr_rsvd_unused;
    assign hdr_rsvd_unused = |hdr_word[HEADER_WIDTH-1:HDR_CNT_W];
    assign hdr_rsvd_err    = 1'b0;
`endif

    assign hdr_err = (hdr_blk == '0) || hdr_rsvd_err;

    assign pay_shift  = en && (state == ST_PAYLOAD);
    assign launch_req = pay_shift && pay_last;

    // The latency counter is loaded on the edge that raises aes_start, so a
    // count of 1 marks the edge that ends the AES_LATENCY-th cycle after it.
    assign capture = en && ((state == ST_PAYLOAD) || (state == ST_DRAIN)) &&
                     (lat_cnt == LCW'(1));
    // A capture on the same edge frees the core, so it is not an overrun.
    assign overrun = launch_req && (lat_cnt != '0) && !capture;
    assign launch  = launch_req && !overrun;

    // Saturating so a pathological count can never wrap back to a match.
    assign blk_cnt_inc = (blk_cnt == '1) ? blk_cnt : blk_cnt + HDR_CNT_W'(1);

    aes_seq_shreg #(.WIDTH(HEADER_WIDTH)) u_hdr_shreg (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .shift_en  (hdr_shift),
        .bit_in    (data_i),
        .word_next (hdr_word),
        .last      (hdr_last)
    );

    aes_seq_shreg #(.WIDTH(AES_DATA_WIDTH)) u_pay_shreg (
        .clk       (clk),
        .rst       (rst),
        .clr       (abort),
        .shift_en  (pay_shift),
        .bit_in    (data_i),
        .word_next (pay_word),
        .last      (pay_last)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        err       = 1'b0;
        pwr_up_en = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_nxt = ST_HEADER;
            end
            ST_HEADER: begin
                if (abort)         state_nxt = ST_IDLE;
                else if (hdr_fire) state_nxt = hdr_err ? ST_ERROR : ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (abort)        state_nxt = ST_IDLE;
                else if (overrun) state_nxt = ST_ERROR;
                else if (launch && (blk_cnt_inc == blk_total)) state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort)        state_nxt = ST_IDLE;
                else if (capture) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                pwr_up_en = 1'b1;
                if (!en) state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                err = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            aes_start <= 1'b0;
            aes_block <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            blk_total <= '0;
            blk_cnt   <= '0;
            lat_cnt   <= '0;
        end else begin
            aes_start <= 1'b0;
            out_valid <= 1'b0;
            if (abort || (state == ST_IDLE)) begin
                // Dropping lat_cnt cancels any capture still in flight.
                blk_total <= '0;
                blk_cnt   <= '0;
                lat_cnt   <= '0;
            end else begin
                if (hdr_fire) blk_total <= hdr_blk;
                if (capture) begin
                    out_data  <= aes_result;
                    out_valid <= 1'b1;
                end
                if (launch) begin
                    aes_block <= pay_word;
                    aes_start <= 1'b1;
                    lat_cnt   <= LCW'(AES_LATENCY);
                    blk_cnt   <= blk_cnt_inc;
                end else if (lat_cnt != '0) begin
                    lat_cnt <= lat_cnt - LCW'(1);
                end
            end
        end
    end

    assign state_dbg = state;

endmodule
